// File: rtl/cdb_arbiter.sv
// cdb_arbiter: buffers one completed result per functional unit and broadcasts up to
// CDB_W buffered tags per cycle on the common data bus, chosen round-robin.
// Any unit whose buffered result loses arbitration is back-pressured.
module cdb_arbiter #(
  parameter int unsigned NUM_FU = 8,
  parameter int unsigned CDB_W  = 3,
  parameter int unsigned PR_W   = 6
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    squash,
  input  logic [NUM_FU-1:0]       fu_done,
  input  logic [NUM_FU*PR_W-1:0]  fu_dest_pr,
  output logic [NUM_FU-1:0]       fu_stall,
  output logic [NUM_FU-1:0]       fu_ready,
  output logic [CDB_W-1:0]        cdb_valid,
  output logic [CDB_W*PR_W-1:0]   cdb_tag
);

  localparam int unsigned PTR_W = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;
  localparam int unsigned SUM_W = PTR_W + 1;
  localparam int unsigned CNT_W = $clog2(CDB_W + 1);

  logic [NUM_FU-1:0]       buf_valid;
  logic [PR_W-1:0]         buf_tag [NUM_FU];
  logic [PTR_W-1:0]        rr_ptr;

  logic [NUM_FU-1:0]       grant;
  logic                    any_grant;
  logic [PTR_W-1:0]        last_idx;
  logic [CDB_W-1:0]        slot_valid;
  logic [CDB_W*PR_W-1:0]   slot_tag;
  logic [CNT_W-1:0]        n_grant;
  logic [SUM_W-1:0]        scan_sum;
  logic [PTR_W-1:0]        scan_idx;
  logic [SUM_W-1:0]        next_sum;
  logic [PTR_W-1:0]        next_ptr;

  // Round-robin scan from rr_ptr: the first CDB_W valid buffers fill slots in order.
  always_comb begin
    grant      = '0;
    any_grant  = 1'b0;
    last_idx   = '0;
    slot_valid = '0;
    slot_tag   = '0;
    n_grant    = '0;
    scan_sum   = '0;
    scan_idx   = '0;
    for (int unsigned k = 0; k < NUM_FU; k++) begin
      scan_sum = SUM_W'(rr_ptr) + SUM_W'(k);
      if (scan_sum >= SUM_W'(NUM_FU)) begin
        scan_sum = scan_sum - SUM_W'(NUM_FU);
      end
      scan_idx = scan_sum[PTR_W-1:0];
      if (buf_valid[scan_idx] && (n_grant < CNT_W'(CDB_W))) begin
        grant[scan_idx]                         = 1'b1;
        slot_valid[n_grant]                     = 1'b1;
        slot_tag[int'(n_grant)*PR_W +: PR_W]    = buf_tag[scan_idx];
        last_idx                                = scan_idx;
        any_grant                               = 1'b1;
        n_grant                                 = n_grant + CNT_W'(1);
      end
    end
  end

  // Pointer advances to just past the last unit granted this cycle.
  always_comb begin
    next_sum = SUM_W'(last_idx) + SUM_W'(1);
    if (next_sum >= SUM_W'(NUM_FU)) begin
      next_sum = next_sum - SUM_W'(NUM_FU);
    end
    next_ptr = next_sum[PTR_W-1:0];
  end

  // A buffer holding a result that lost arbitration stalls its unit.
  assign fu_stall = buf_valid & ~grant;
  assign fu_ready = ~fu_stall;

  // Result buffers, round-robin pointer and registered CDB slots.
  always_ff @(posedge clock) begin
    if (reset) begin
      buf_valid <= '0;
      rr_ptr    <= '0;
      cdb_valid <= '0;
      cdb_tag   <= '0;
      for (int unsigned i = 0; i < NUM_FU; i++) begin
        buf_tag[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < NUM_FU; i++) begin
        if (squash) begin
          buf_valid[i] <= 1'b0;
        end else if (fu_done[i] && (!buf_valid[i] || grant[i])) begin
          buf_valid[i] <= 1'b1;
          buf_tag[i]   <= fu_dest_pr[i*PR_W +: PR_W];
        end else if (grant[i]) begin
          buf_valid[i] <= 1'b0;
        end
      end
      if (squash) begin
        cdb_valid <= '0;
        cdb_tag   <= '0;
      end else begin
        cdb_valid <= slot_valid;
        cdb_tag   <= slot_tag;
        if (any_grant) begin
          rr_ptr <= next_ptr;
        end
      end
    end
  end

  // A unit must not complete while its previous result is still held.
  illegal_done_a: assert property (@(posedge clock) disable iff (reset)
    ((fu_done & fu_stall) == '0))
    else $warning("cdb_arbiter: fu_done while stalled, ignored, mask %b", fu_done & fu_stall);

endmodule

// File: tb/tb_cdb_arbiter.sv
// Testbench for cdb_arbiter: directed vector table, hand-built corner sequences and
// randomized traffic checked against a queue-based reference model.
module tb_cdb_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic        squash;
  logic [7:0]  fu_done;
  logic [47:0] fu_dest_pr;
  logic [7:0]  fu_stall;
  logic [7:0]  fu_ready;
  logic [2:0]  cdb_valid;
  logic [17:0] cdb_tag;

  int n_checks = 0;
  int n_fail   = 0;

  cdb_arbiter dut (
    .clock      (clock),
    .reset      (reset),
    .squash     (squash),
    .fu_done    (fu_done),
    .fu_dest_pr (fu_dest_pr),
    .fu_stall   (fu_stall),
    .fu_ready   (fu_ready),
    .cdb_valid  (cdb_valid),
    .cdb_tag    (cdb_tag)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        rst;
    logic        sq;
    logic [7:0]  done;
    logic [47:0] tags;
    logic [7:0]  stall;
    logic [2:0]  valid;
    logic [17:0] tag;
    logic [2:0]  ptr;
  } vec_t;

  // Reference model: pending flag and tag per unit plus the round-robin start point.
  bit         m_pend [8];
  logic [5:0] m_tag  [8];
  int         m_ptr;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [47:0] one_tag(input int fu, input int tag);
    logic [47:0] v;
    v = 48'(tag) << (fu * 6);
    return v;
  endfunction

  function automatic logic [47:0] seq_tags(input logic [7:0] mask, input int base);
    logic [47:0] v = '0;
    for (int i = 0; i < 8; i++)
      if (mask[i]) v = v | one_tag(i, base + i);
    return v;
  endfunction

  // Drive one cycle, check stall/ready before the edge and CDB/pointer after it.
  task automatic cyc(input logic rst, input logic sq, input logic [7:0] done,
                     input logic [47:0] tags, input logic [7:0] e_stall,
                     input logic [2:0] e_valid, input logic [17:0] e_tag,
                     input logic [2:0] e_ptr);
    logic [7:0] e_ready;
    e_ready    = ~e_stall;
    reset      = rst;
    squash     = sq;
    fu_done    = done;
    fu_dest_pr = tags;
    #1;
    chk("fu_stall", 64'(fu_stall), 64'(e_stall));
    chk("fu_ready", 64'(fu_ready), 64'(e_ready));
    @(posedge clock);
    #1;
    chk("cdb_valid", 64'(cdb_valid), 64'(e_valid));
    chk("cdb_tag",   64'(cdb_tag),   64'(e_tag));
    chk("rr_ptr",    64'(dut.rr_ptr), 64'(e_ptr));
  endtask

  // Units the model would grant this cycle: first three pending, scanning from m_ptr.
  function automatic logic [7:0] m_grants();
    logic [7:0] g = '0;
    int taken = 0;
    for (int d = 0; d < 8; d++) begin
      int idx = (m_ptr + d) % 8;
      if (m_pend[idx] && taken < 3) begin
        g[idx] = 1'b1;
        taken++;
      end
    end
    return g;
  endfunction

  task automatic model_step(input logic rst, input logic sq, input logic [7:0] done,
                            input logic [47:0] tags, output logic [2:0] ev,
                            output logic [17:0] et, output logic [2:0] ep);
    int q[$];
    logic [7:0] g = '0;
    for (int d = 0; d < 8; d++) begin
      int idx = (m_ptr + d) % 8;
      if (m_pend[idx]) q.push_back(idx);
    end
    while (q.size() > 3) void'(q.pop_back());
    foreach (q[s]) g[q[s]] = 1'b1;
    ev = '0;
    et = '0;
    if (rst) begin
      foreach (m_pend[i]) m_pend[i] = 1'b0;
      m_ptr = 0;
    end else if (sq) begin
      foreach (m_pend[i]) m_pend[i] = 1'b0;
    end else begin
      foreach (q[s]) begin
        ev[s]         = 1'b1;
        et[s*6 +: 6]  = m_tag[q[s]];
      end
      for (int i = 0; i < 8; i++) begin
        bit held = m_pend[i] && !g[i];
        if (done[i] && !held) begin
          m_pend[i] = 1'b1;
          m_tag[i]  = tags[i*6 +: 6];
        end else if (g[i]) begin
          m_pend[i] = 1'b0;
        end
      end
      if (q.size() > 0) m_ptr = (q[q.size()-1] + 1) % 8;
    end
    ep = 3'(m_ptr);
  endtask

  vec_t tbl[10];

  initial begin
    logic [47:0] all_tags;
    all_tags = {6'd8, 6'd7, 6'd6, 6'd5, 6'd4, 6'd3, 6'd2, 6'd1};

    // Single completion latency, then all eight completing at once from rr_ptr=0.
    tbl[0] = '{1'b0, 1'b0, 8'h01, 48'd5,    8'h00, 3'b000, 18'd0, 3'd0};
    tbl[1] = '{1'b0, 1'b0, 8'h00, 48'd0,    8'h00, 3'b001, 18'd5, 3'd1};
    tbl[2] = '{1'b0, 1'b0, 8'h00, 48'd0,    8'h00, 3'b000, 18'd0, 3'd1};
    tbl[3] = '{1'b1, 1'b0, 8'h00, 48'd0,    8'h00, 3'b000, 18'd0, 3'd0};
    tbl[4] = '{1'b0, 1'b0, 8'hFF, all_tags, 8'h00, 3'b000, 18'd0, 3'd0};
    tbl[5] = '{1'b0, 1'b0, 8'h00, 48'd0,    8'hF8, 3'b111, {6'd3, 6'd2, 6'd1}, 3'd3};
    tbl[6] = '{1'b0, 1'b0, 8'h00, 48'd0,    8'hC0, 3'b111, {6'd6, 6'd5, 6'd4}, 3'd6};
    tbl[7] = '{1'b0, 1'b0, 8'h00, 48'd0,    8'h00, 3'b011, {6'd0, 6'd8, 6'd7}, 3'd0};
    tbl[8] = '{1'b0, 1'b0, 8'h00, 48'd0,    8'h00, 3'b000, 18'd0, 3'd0};
    tbl[9] = '{1'b0, 1'b0, 8'h00, 48'd0,    8'h00, 3'b000, 18'd0, 3'd0};

    reset = 1'b1; squash = 1'b0; fu_done = '0; fu_dest_pr = '0;
    repeat (2) @(posedge clock);
    #1;
    chk("reset cdb_valid", 64'(cdb_valid), 64'd0);
    chk("reset cdb_tag",   64'(cdb_tag),   64'd0);
    chk("reset fu_stall",  64'(fu_stall),  64'h00);
    chk("reset fu_ready",  64'(fu_ready),  64'hFF);
    chk("reset rr_ptr",    64'(dut.rr_ptr), 64'd0);

    foreach (tbl[i])
      cyc(tbl[i].rst, tbl[i].sq, tbl[i].done, tbl[i].tags,
          tbl[i].stall, tbl[i].valid, tbl[i].tag, tbl[i].ptr);

    // Stalled FU 4 holds tag 9; an illegal completion with tag 12 is dropped.
    cyc(1'b0, 1'b0, 8'h17, one_tag(0,1) | one_tag(1,2) | one_tag(2,3) | one_tag(4,9),
        8'h00, 3'b000, 18'd0, 3'd0);
    cyc(1'b0, 1'b0, 8'h10, one_tag(4,12), 8'h10, 3'b111, {6'd3, 6'd2, 6'd1}, 3'd3);
    cyc(1'b0, 1'b0, 8'h00, 48'd0, 8'h00, 3'b001, 18'd9, 3'd5);
    cyc(1'b0, 1'b0, 8'h00, 48'd0, 8'h00, 3'b000, 18'd0, 3'd5);

    // Back-to-back completions on FU 7 while its buffer is being granted.
    cyc(1'b0, 1'b0, 8'h80, one_tag(7,20), 8'h00, 3'b000, 18'd0,  3'd5);
    cyc(1'b0, 1'b0, 8'h80, one_tag(7,21), 8'h00, 3'b001, 18'd20, 3'd0);
    cyc(1'b0, 1'b0, 8'h00, 48'd0,         8'h00, 3'b001, 18'd21, 3'd0);
    cyc(1'b0, 1'b0, 8'h00, 48'd0,         8'h00, 3'b000, 18'd0,  3'd0);

    // Walk rr_ptr to 6, then pend FUs 0, 6, 7 to exercise wrap-around.
    cyc(1'b0, 1'b0, 8'h3F, seq_tags(8'h3F, 40), 8'h00, 3'b000, 18'd0, 3'd0);
    cyc(1'b0, 1'b0, 8'h00, 48'd0, 8'h38, 3'b111, {6'd42, 6'd41, 6'd40}, 3'd3);
    cyc(1'b0, 1'b0, 8'h00, 48'd0, 8'h00, 3'b111, {6'd45, 6'd44, 6'd43}, 3'd6);
    cyc(1'b0, 1'b0, 8'hC1, one_tag(0,30) | one_tag(6,36) | one_tag(7,37),
        8'h00, 3'b000, 18'd0, 3'd6);
    cyc(1'b0, 1'b0, 8'h00, 48'd0, 8'h00, 3'b111, {6'd30, 6'd37, 6'd36}, 3'd1);
    cyc(1'b0, 1'b0, 8'h00, 48'd0, 8'h00, 3'b000, 18'd0, 3'd1);

    // Squash with five pending buffers: nothing broadcast, pointer unchanged.
    cyc(1'b0, 1'b0, 8'h3E, seq_tags(8'h3E, 50), 8'h00, 3'b000, 18'd0, 3'd1);
    cyc(1'b0, 1'b1, 8'h00, 48'd0, 8'h30, 3'b000, 18'd0, 3'd1);
    cyc(1'b0, 1'b0, 8'h00, 48'd0, 8'h00, 3'b000, 18'd0, 3'd1);

    // Reset mid-operation with all buffers full.
    cyc(1'b0, 1'b0, 8'hFF, all_tags, 8'h00, 3'b000, 18'd0, 3'd1);
    cyc(1'b1, 1'b1, 8'hFF, all_tags, 8'hF1, 3'b000, 18'd0, 3'd0);
    cyc(1'b0, 1'b0, 8'h00, 48'd0,    8'h00, 3'b000, 18'd0, 3'd0);

    // Randomized legal traffic against the reference model.
    foreach (m_pend[i]) begin
      m_pend[i] = 1'b0;
      m_tag[i]  = '0;
    end
    m_ptr = 0;
    for (int c = 0; c < 600; c++) begin
      logic [7:0]  m_stall, done, dens;
      logic [47:0] tags;
      logic        rst, sq;
      logic [2:0]  ev, ep;
      logic [17:0] et;
      m_stall = 8'({m_pend[7], m_pend[6], m_pend[5], m_pend[4],
                    m_pend[3], m_pend[2], m_pend[1], m_pend[0]}) & ~m_grants();
      dens    = ((c / 150) % 2 == 0) ? 8'hFF : 8'($urandom);
      done    = 8'($urandom) & dens & ~m_stall;
      tags    = {16'($urandom), 32'($urandom)};
      sq      = ($urandom_range(0, 15) == 0);
      rst     = ($urandom_range(0, 79) == 0);
      model_step(rst, sq, done, tags, ev, et, ep);
      cyc(rst, sq, done, tags, m_stall, ev, et, ep);
    end

    reset = 1'b0; squash = 1'b0; fu_done = '0; fu_dest_pr = '0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
